// File: rtl/register_dump_reader.sv
// register_dump_reader: DEPTH x WIDTH register bank with two combinational read ports and a handshaked dump engine.
// Ports:
//   clock_i, reset_i              rising-edge clock, synchronous active-high reset
//   enable_i, write_addr_i,       write regs[write_addr_i] <= indata_i when enable_i=1
//   indata_i
//   read_addr_a_i/_b_i            random-read addresses
//   outdata_a_o/_b_o              regs[read_addr_*], combinational, no write bypass
//   dump_start_i                  start a full dump (sampled in IDLE only)
//   dump_ready_i                  consumer accepts the presented dump word
//   dump_valid_o                  dump_addr_o/dump_data_o hold a word
//   dump_addr_o, dump_data_o      index and captured contents of the presented word
//   dump_busy_o                   dump engine not idle
//   dump_done_o                   one-cycle pulse after the last word is accepted
module register_dump_reader #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic [AW-1:0]    write_addr_i,
    input  logic [WIDTH-1:0] indata_i,
    input  logic [AW-1:0]    read_addr_a_i,
    input  logic [AW-1:0]    read_addr_b_i,
    output logic [WIDTH-1:0] outdata_a_o,
    output logic [WIDTH-1:0] outdata_b_o,
    input  logic             dump_start_i,
    input  logic             dump_ready_i,
    output logic             dump_valid_o,
    output logic [AW-1:0]    dump_addr_o,
    output logic [WIDTH-1:0] dump_data_o,
    output logic             dump_busy_o,
    output logic             dump_done_o
);
    typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_e;
    state_e           state_q, state_d;
    logic [AW-1:0]    index_q, index_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] regs_q [DEPTH];
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            index_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            if (enable_i) regs_q[write_addr_i] <= indata_i;
        end
    end
    // LOAD captures from regs_q before this edge's write lands, so a
    // same-cycle write to the word being loaded is deliberately missed.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            IDLE: if (dump_start_i) begin
                index_d = '0;
                state_d = LOAD;
            end
            LOAD: begin
                data_d  = regs_q[index_q];
                addr_d  = index_q;
                state_d = SEND;
            end
            SEND: if (dump_ready_i) begin
                if (index_q == AW'(DEPTH - 1)) state_d = DONE;
                else begin
                    index_d = index_q + 1'b1;
                    state_d = LOAD;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    assign outdata_a_o  = regs_q[read_addr_a_i];
    assign outdata_b_o  = regs_q[read_addr_b_i];
    assign dump_valid_o = state_q == SEND;
    assign dump_busy_o  = state_q != IDLE;
    assign dump_done_o  = state_q == DONE;
    assign dump_addr_o  = addr_q;
    assign dump_data_o  = data_q;
endmodule
